// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, falling-edge start detect and
// mid-bit sampling with CLKS_PER_BIT system clocks per serial bit.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk_sis,
  input  logic       rst,
  input  logic       rx2,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state, state_n;

  logic             rx_s1, rx_s, rx_prev;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic [7:0]       data_out_n;
  logic             data_valid_n, frame_err_n;

  // rx2 is asynchronous; rx_prev gives the edge detector a one-cycle history
  always_ff @(posedge clk_sis or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx2;
      rx_s    <= rx_s1;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk_sis or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      data_out   <= data_out_n;
      data_valid <= data_valid_n;
      frame_err  <= frame_err_n;
    end
  end

  // Only a high-to-low transition starts a frame, so a stuck-low line cannot retrigger
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    bit_idx_n    = bit_idx;
    shreg_n      = shreg;
    data_out_n   = data_out;
    data_valid_n = 1'b0;
    frame_err_n  = 1'b0;

    case (state)
      IDLE: begin
        if (!rx_s && rx_prev) begin
          state_n = START;
          cnt_n   = '0;
        end
      end

      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n   = DATA;
            bit_idx_n = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n            = '0;
          shreg_n[bit_idx] = rx_s;
          bit_idx_n        = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (rx_s) begin
            data_out_n   = shreg;
            data_valid_n = 1'b1;
          end else begin
            frame_err_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives serial frames and compares strobes, timing and
// held data against a frame-level model of the receiver.
module tb_uart_rx;

  localparam int CPB   = 16;
  localparam int HALF  = CPB / 2;
  localparam int FRAME = 10 * CPB;
  // cycles from the negedge that drops rx2 to the negedge observing the strobe
  localparam int PULSE_LAT = 1 + 2 + HALF + 9 * CPB;
  localparam int FRAME_BUSY = PULSE_LAT - 3;
  localparam int QN = 64;

  logic       clk_sis = 1'b0;
  logic       rst = 1'b1;
  logic       rx2 = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_sis   (clk_sis),
    .rst       (rst),
    .rx2       (rx2),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk_sis = ~clk_sis;

  int cyc = 0;
  always @(posedge clk_sis) cyc++;

  // observed strobe log, written only by the monitor
  int         ev_cyc [0:QN-1];
  logic [1:0] ev_kind[0:QN-1];
  logic [7:0] ev_data[0:QN-1];
  int         ev_wr = 0;
  int         busy_total = 0;
  int         overlap_cnt = 0;

  always @(negedge clk_sis) begin
    if (busy === 1'b1) busy_total++;
    if (data_valid === 1'b1 && frame_err === 1'b1) overlap_cnt++;
    if (data_valid !== 1'b0 || frame_err !== 1'b0) begin
      if (ev_wr < QN) begin
        ev_cyc[ev_wr]  = cyc;
        ev_kind[ev_wr] = {frame_err, data_valid};
        ev_data[ev_wr] = data_out;
      end
      ev_wr++;
    end
  end

  // expected strobe log from the frame-level model
  int         exp_cyc [0:QN-1];
  logic [1:0] exp_kind[0:QN-1];
  logic [7:0] exp_data[0:QN-1];
  int         exp_wr = 0;
  int         exp_rd = 0;
  int         ev_rd = 0;
  logic [7:0] model_out = 8'h00;

  int n_assert = 0;
  int n_fail = 0;
  int busy_mark;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic idle(input int n);
    rx2 = 1'b1;
    repeat (n) @(negedge clk_sis);
  endtask

  task automatic expect_event(input int at, input logic [1:0] kind, input logic [7:0] d);
    if (exp_wr < QN) begin
      exp_cyc[exp_wr]  = at;
      exp_kind[exp_wr] = kind;
      exp_data[exp_wr] = d;
    end
    exp_wr++;
  endtask

  // drives start, 8 data bits LSB first and the stop bit; stops early after n_cycles
  task automatic apply_stimulus(input logic [7:0] b, input logic stop_bit, input int n_cycles);
    logic [9:0] bits;
    int fall;
    bits = {stop_bit, b, 1'b0};
    fall = cyc;
    for (int i = 0; i < n_cycles; i++) begin
      rx2 = bits[i / CPB];
      @(negedge clk_sis);
    end
    if (n_cycles == FRAME) begin
      if (stop_bit) begin
        expect_event(fall + PULSE_LAT, 2'b01, b);
        model_out = b;
      end else begin
        expect_event(fall + PULSE_LAT, 2'b10, model_out);
      end
    end
  endtask

  task automatic check_events(input string tag);
    int n_obs, n_exp, n;
    n_obs = ev_wr - ev_rd;
    n_exp = exp_wr - exp_rd;
    check_output({tag, "_count"}, n_obs, n_exp);
    n = (n_obs < n_exp) ? n_obs : n_exp;
    for (int i = 0; i < n; i++) begin
      if (ev_rd + i < QN && exp_rd + i < QN) begin
        check_output({tag, "_cycle"}, ev_cyc[ev_rd + i], exp_cyc[exp_rd + i]);
        check_output({tag, "_kind"}, {30'd0, ev_kind[ev_rd + i]}, {30'd0, exp_kind[exp_rd + i]});
        check_output({tag, "_data"}, {24'd0, ev_data[ev_rd + i]}, {24'd0, exp_data[exp_rd + i]});
      end
    end
    ev_rd  = ev_wr;
    exp_rd = exp_wr;
    check_output({tag, "_data_out"}, {24'd0, data_out}, {24'd0, model_out});
    check_output({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs;

    // reset and idle line
    rst = 1'b1;
    rx2 = 1'b1;
    repeat (3) @(negedge clk_sis);
    check_output("rst_data_out", {24'd0, data_out}, 32'd0);
    check_output("rst_valid", {31'd0, data_valid}, 32'd0);
    check_output("rst_ferr", {31'd0, frame_err}, 32'd0);
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    busy_mark = busy_total;
    idle(50);
    check_events("idle");
    check_output("idle_busy_cycles", busy_total - busy_mark, 0);

    // single frame with latency and busy window
    busy_mark = busy_total;
    apply_stimulus(8'hA5, 1'b1, FRAME);
    idle(20);
    check_events("a5");
    check_output("a5_busy_cycles", busy_total - busy_mark, FRAME_BUSY);

    // back-to-back frames without an idle gap
    apply_stimulus(8'h00, 1'b1, FRAME);
    apply_stimulus(8'hFF, 1'b1, FRAME);
    apply_stimulus(8'h3C, 1'b1, FRAME);
    idle(20);
    check_events("b2b");

    // short low glitch is rejected at the start-bit sample
    busy_mark = busy_total;
    rx2 = 1'b0;
    repeat (4) @(negedge clk_sis);
    idle(30);
    check_events("glitch");
    check_output("glitch_busy_cycles", busy_total - busy_mark, HALF);

    // bad stop bit, then a good frame
    apply_stimulus(8'h5A, 1'b0, FRAME);
    idle(CPB);
    apply_stimulus(8'h81, 1'b1, FRAME);
    idle(20);
    check_events("stoperr");

    // reset in the middle of data bit 4
    apply_stimulus(8'hC3, 1'b1, 5 * CPB + HALF);
    rst = 1'b1;
    rx2 = 1'b1;
    model_out = 8'h00;
    @(negedge clk_sis);
    check_output("midrst_data_out", {24'd0, data_out}, 32'd0);
    check_output("midrst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk_sis);
    rst = 1'b0;
    idle(20);
    check_events("midrst");
    apply_stimulus(8'h7E, 1'b1, FRAME);
    idle(20);
    check_events("after_rst");

    // line held low through reset release: one frame error, no retrigger
    rst = 1'b1;
    rx2 = 1'b0;
    model_out = 8'h00;
    repeat (3) @(negedge clk_sis);
    rst = 1'b0;
    expect_event(cyc + PULSE_LAT, 2'b10, model_out);
    repeat (400) @(negedge clk_sis);
    idle(20);
    check_events("held_low");

    // random bytes with occasional bad stop bits
    for (int k = 0; k < 8; k++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      apply_stimulus(rb, rs, FRAME);
      if (rs) idle($urandom_range(0, 3));
      else    idle(CPB);
    end
    idle(20);
    check_events("random");

    check_output("pulse_overlap", overlap_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver stage directly downstream of the UART transmitter. It consumes the transmitter's `tx1` line, wired here as `rx2`, and recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) using a single system clock oversampled at `CLKS_PER_BIT` cycles per bit. Each good frame produces a parallel byte with a one-cycle valid strobe. Bad stop bits are flagged instead of delivered.

## Interface
- `CLKS_PER_BIT`, default 16: system clock cycles per serial bit. Must be even and ≥ 4; HALF = `CLKS_PER_BIT`/2.
- `clk_sis`, input, 1: system clock. All state updates on its rising edge.
- `rst`, input, 1: reset. Asynchronous and active-high.
- `rx2`, input, 1: serial line. Idle high; asynchronous to `clk_sis`.
- `data_out`, output, 8: last correctly received byte. Held until the next good frame.
- `data_valid`, output, 1: one-cycle pulse when `data_out` updates.
- `frame_err`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `busy`, output, 1: high while the state is not IDLE.

## Operation
- Synchronizer: 2 flops `rx_s1` → `rx_s`, then an edge register `rx_prev` ← `rx_s`. All three reset to 1.
- Start condition: `rx_s`=0 and `rx_prev`=1 (falling edge). A line already low does not retrigger.
- IDLE: on start condition, go to START with `cnt`=0.
- START: `cnt` increments each cycle. When `cnt`==HALF-1, sample `rx_s`:
  - 0: go to DATA, `cnt`=0, `bit_idx`=0.
  - 1: false start (glitch); return to IDLE with no output pulse.
- DATA: when `cnt`==`CLKS_PER_BIT`-1, shift `rx_s` into `shreg[bit_idx]` (LSB first), set `cnt`=0 and `bit_idx`++.
  - After the sample with `bit_idx`==7, go to STOP.
- STOP: when `cnt`==`CLKS_PER_BIT`-1, sample `rx_s`, then go to IDLE:
  - 1: `data_out` ← `shreg`, `data_valid` pulses.
  - 0: `frame_err` pulses; `data_out` is unchanged.
- `cnt` is ⌈log2(`CLKS_PER_BIT`)⌉ bits wide and cleared on every state transition. `bit_idx` is 3 bits.
- `data_valid` and `frame_err` are never high together, and each is high for exactly one cycle per frame.
- Reset (any time, including mid-frame):
  - State goes to IDLE; `cnt`, `bit_idx` and `shreg` clear.
  - `data_out`=0x00, `data_valid`=0, `frame_err`=0, `busy`=0.
  - The partial frame is discarded with no pulse.
- Line held low across reset release: seen as a falling edge after synchronization. The frame is received, its stop bit samples low, and `frame_err` pulses once. No further triggers occur until the line returns high and falls again.
- Back-to-back frames: a start bit immediately after the stop bit is accepted. The stop-bit mid-sample leaves at least HALF cycles before the next falling edge reaches IDLE.

## Timing
- Let E0 be the first `clk_sis` edge after `rx2` falls.
  - `rx_s` goes low at E1.
  - START entered at E2.
  - Start sample at E2+HALF.
  - Data bit n sampled at E2+HALF+(n+1)·`CLKS_PER_BIT`.
  - Stop bit sampled at E2+HALF+9·`CLKS_PER_BIT`.
  - `data_valid`/`frame_err` high during the cycle after that edge; `busy` drops the same cycle.
- With `CLKS_PER_BIT`=16, the pulse is registered at E154; `busy` is high from E2 through E153.
- Samples fall at bit centers, ±2 cycles of synchronizer skew.
- Baud mismatch tolerated: ±(HALF-2)/(9.5·`CLKS_PER_BIT`).
- Throughput: one byte per 10·`CLKS_PER_BIT` cycles, with no gap required.

## Test plan
- Reset, `rx2` idle high for 50 cycles → all outputs 0, `busy`=0, no pulses.
- Frame 0xA5 at `CLKS_PER_BIT`=16 → `data_valid` high for exactly 1 cycle at E154, `data_out`=0xA5, `frame_err`=0.
- Back-to-back frames 0x00, 0xFF, 0x3C, no idle gap → three `data_valid` pulses 160 cycles apart with matching `data_out`.
- `rx2` low glitch of 4 cycles → `busy` high for about 8 cycles, then IDLE; no `data_valid`, no `frame_err`.
- Frame 0x5A with stop bit forced 0 → `frame_err` pulses once, `data_valid` stays 0, `data_out` keeps the previous byte. A following valid 0x81 frame is received correctly.
- `rst` asserted during bit 4 of 0xC3, released, then a new 0x7E frame → no pulse for 0xC3; `data_out`=0x00 after reset, then 0x7E with one `data_valid` pulse.
